// File: rtl/lpc_frame_sequencer_if.sv
// Signal bundle between the LPC frame sequencer, the audio front end,
// the bitstream packer and the encoder core's register ports.
interface lpc_frame_sequencer_if #(
  parameter int ORDER = 10
);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic             out_type;
  logic             out_last;
  logic             start;
  logic             rfin;
  logic             rready;
  logic             x_wen;
  logic [7:0]       x_waddr;
  logic [15:0]      x_din;
  logic [7:0]       residue_raddr;
  logic [15:0]      residue_dout;
  logic [ORDER-1:0] a_rsel;
  logic [31:0]      a_dout;
  logic             busy;
  logic [15:0]      frame_cnt;

  modport master (
    input  in_valid, in_data, out_ready, rready, residue_dout, a_dout,
    output in_ready, out_valid, out_data, out_type, out_last, start, rfin,
           x_wen, x_waddr, x_din, residue_raddr, a_rsel, busy, frame_cnt
  );

  modport slave (
    output in_valid, in_data, out_ready, rready, residue_dout, a_dout,
    input  in_ready, out_valid, out_data, out_type, out_last, start, rfin,
           x_wen, x_waddr, x_din, residue_raddr, a_rsel, busy, frame_cnt
  );
endinterface

// File: rtl/lpc_frame_sequencer.sv
// Frame scheduler for the LPC encoder: fills one frame of samples, launches
// the core, drains coefficients then residues, and releases the core.
module lpc_frame_sequencer #(
  parameter int FRAME_LEN = 160,
  parameter int ORDER     = 10
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  lpc_frame_sequencer_if.master bus
);
  localparam logic [7:0]       LAST_SAMPLE = 8'(FRAME_LEN - 1);
  localparam logic [7:0]       LAST_COEF   = 8'(ORDER - 1);
  localparam logic [ORDER-1:0] SEL_ONE     = {{(ORDER-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_FILL    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_WAIT    = 3'd2,
    S_DRAIN_A = 3'd3,
    S_DRAIN_R = 3'd4,
    S_RELEASE = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       idx_q, idx_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             in_ready_q, busy_q, start_q, rfin_q;
  logic             out_valid_q, out_type_q, out_last_q;
  logic [ORDER-1:0] a_rsel_q;
  logic [7:0]       raddr_q;
  logic             x_wen_s, hs_s;

  assign x_wen_s = in_ready_q & bus.in_valid;
  assign hs_s    = out_valid_q & bus.out_ready;

  // Next state and index; the index only advances on an accepted sample or beat.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      S_FILL: begin
        if (x_wen_s) begin
          if (idx_q == LAST_SAMPLE) begin
            idx_d   = 8'd0;
            state_d = S_LAUNCH;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end else begin
          idx_d = idx_q;
        end
      end
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.rready) begin
          idx_d   = 8'd0;
          state_d = S_DRAIN_A;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DRAIN_A: begin
        if (hs_s) begin
          if (idx_q == LAST_COEF) begin
            idx_d   = 8'd0;
            state_d = S_DRAIN_R;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end else begin
          idx_d = idx_q;
        end
      end
      S_DRAIN_R: begin
        if (hs_s) begin
          if (idx_q == LAST_SAMPLE) begin
            idx_d   = 8'd0;
            state_d = S_RELEASE;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end else begin
          idx_d = idx_q;
        end
      end
      S_RELEASE: begin
        idx_d       = 8'd0;
        frame_cnt_d = frame_cnt_q + 16'd1;
        state_d     = S_FILL;
      end
      default: begin
        idx_d   = 8'd0;
        state_d = S_FILL;
      end
    endcase
  end

  // State register; control outputs are registered from the next state.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_FILL;
      idx_q       <= 8'd0;
      frame_cnt_q <= 16'd0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      start_q     <= 1'b0;
      rfin_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_type_q  <= 1'b0;
      out_last_q  <= 1'b0;
      a_rsel_q    <= {ORDER{1'b0}};
      raddr_q     <= 8'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      frame_cnt_q <= frame_cnt_d;
      in_ready_q  <= (state_d == S_FILL);
      busy_q      <= (state_d != S_FILL);
      start_q     <= (state_d == S_LAUNCH);
      rfin_q      <= (state_d == S_RELEASE);
      out_valid_q <= (state_d == S_DRAIN_A) || (state_d == S_DRAIN_R);
      out_type_q  <= (state_d == S_DRAIN_R);
      out_last_q  <= (state_d == S_DRAIN_R) && (idx_d == LAST_SAMPLE);
      a_rsel_q    <= (state_d == S_DRAIN_A) ? (SEL_ONE << idx_d) : {ORDER{1'b0}};
      raddr_q     <= (state_d == S_DRAIN_R) ? idx_d : 8'd0;
    end
  end

  // Beat data follows the registered selects; residues are sign-extended.
  always_comb begin
    if (!out_valid_q) begin
      bus.out_data = 32'd0;
    end else if (out_type_q) begin
      bus.out_data = {{16{bus.residue_dout[15]}}, bus.residue_dout};
    end else begin
      bus.out_data = bus.a_dout;
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.busy          = busy_q;
  assign bus.start         = start_q;
  assign bus.rfin          = rfin_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_type      = out_type_q;
  assign bus.out_last      = out_last_q;
  assign bus.a_rsel        = a_rsel_q;
  assign bus.residue_raddr = raddr_q;
  assign bus.frame_cnt     = frame_cnt_q;
  assign bus.x_wen         = x_wen_s;
  assign bus.x_waddr       = x_wen_s ? idx_q : 8'd0;
  assign bus.x_din         = x_wen_s ? bus.in_data : 16'd0;
endmodule

// File: tb/tb_lpc_frame_sequencer.sv
// Self-checking bench for lpc_frame_sequencer: reset/fill vector table plus
// randomized frames checked against a beat-list model of one encoded frame.
module tb_lpc_frame_sequencer;
  localparam int FL = 160;
  localparam int ORD = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   enc_ofs = 0;

  lpc_frame_sequencer_if #(.ORDER(ORD)) bus ();

  lpc_frame_sequencer #(.FRAME_LEN(FL), .ORDER(ORD)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Encoder read ports: combinational from address/select.
  always_comb begin
    bus.a_dout = 32'h0;
    for (int k = 0; k < ORD; k++) begin
      if (bus.a_rsel[k]) bus.a_dout = 32'(k + enc_ofs) * 32'h01010101;
    end
    bus.residue_dout = 16'(32'h8000 + 32'(bus.residue_raddr) + 32'(enc_ofs));
  end

  typedef struct {
    bit          typ;
    logic [31:0] data;
    bit          last;
    logic [9:0]  sel;
    logic [7:0]  raddr;
    int          idx;
  } beat_t;

  typedef struct {
    bit          rst;
    bit          iv;
    logic [15:0] din;
    bit          e_wen;
    logic [7:0]  e_addr;
    logic [15:0] e_din;
    bit          e_ready;
    bit          e_busy;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; bus.in_valid = 1'b0; bus.in_data = 16'h0;
    bus.out_ready = 1'b0; bus.rready = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  // Collect one frame: FL samples, then the launch cycle.
  task automatic fill(input int duty, input bit rnd, input int exp_cnt, input bit keep_iv);
    int n = 0;
    int cyc = 0;
    while (n < FL && cyc < 3000) begin
      logic [15:0] d;
      bit iv;
      @(negedge clk);
      cyc++;
      iv = ($urandom_range(99) < duty);
      d  = rnd ? 16'($urandom) : 16'(n);
      rst = 1'b0; bus.in_valid = iv; bus.in_data = d;
      bus.out_ready = 1'($urandom); bus.rready = 1'b0;
      #1;
      chk("fill_in_ready", bus.in_ready, 1'b1);
      chk("fill_busy", bus.busy, 1'b0);
      chk("fill_x_wen", bus.x_wen, iv);
      chk("fill_out_valid", bus.out_valid, 1'b0);
      chk("fill_start", bus.start, 1'b0);
      chk("fill_rfin", bus.rfin, 1'b0);
      chk("fill_frame_cnt", bus.frame_cnt, 32'(exp_cnt));
      if (iv) begin
        chk("fill_x_waddr", bus.x_waddr, 32'(n));
        chk("fill_x_din", bus.x_din, d);
        n++;
      end
    end
    if (n < FL) chk("fill_timeout", 32'(n), 32'(FL));
    @(negedge clk);
    bus.in_valid = keep_iv;
    #1;
    chk("launch_start", bus.start, 1'b1);
    chk("launch_in_ready", bus.in_ready, 1'b0);
    chk("launch_busy", bus.busy, 1'b1);
    chk("launch_x_wen", bus.x_wen, 1'b0);
    chk("launch_out_valid", bus.out_valid, 1'b0);
  endtask

  // Hold rready low for n cycles, then raise it for the sampling WAIT cycle.
  task automatic wait_phase(input int n, input bit keep_iv);
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      bus.in_valid = keep_iv; bus.rready = (i == n);
      #1;
      chk("wait_out_valid", bus.out_valid, 1'b0);
      chk("wait_in_ready", bus.in_ready, 1'b0);
      chk("wait_start", bus.start, 1'b0);
      chk("wait_x_wen", bus.x_wen, 1'b0);
    end
  endtask

  // Drain against the expected beat list; abort_res>=0 asserts reset on that residue.
  task automatic drain(input int duty, input int abort_res, input bit keep_iv, output int cycles);
    beat_t q[$];
    int cyc = 0;
    bit done = 1'b0;
    for (int k = 0; k < ORD; k++) begin
      beat_t b;
      b.typ = 1'b0; b.data = 32'(k + enc_ofs) * 32'h01010101; b.last = 1'b0;
      b.sel = 10'd1 << k; b.raddr = 8'd0; b.idx = k;
      q.push_back(b);
    end
    for (int i = 0; i < FL; i++) begin
      beat_t b;
      logic [15:0] r;
      r = 16'(32'h8000 + 32'(i) + 32'(enc_ofs));
      b.typ = 1'b1; b.data = 32'($signed(r)); b.last = (i == FL - 1);
      b.sel = 10'd0; b.raddr = 8'(i); b.idx = i;
      q.push_back(b);
    end
    while (!done && cyc < 4000) begin
      bit rdy;
      @(negedge clk);
      cyc++;
      rdy = ($urandom_range(99) < duty);
      bus.in_valid = keep_iv; bus.out_ready = rdy; bus.rready = 1'b1;
      rst = (abort_res >= 0 && q[0].typ && q[0].idx == abort_res);
      #1;
      chk("drain_out_valid", bus.out_valid, 1'b1);
      chk("drain_in_ready", bus.in_ready, 1'b0);
      chk("drain_x_wen", bus.x_wen, 1'b0);
      chk("drain_rfin", bus.rfin, 1'b0);
      chk("drain_busy", bus.busy, 1'b1);
      chk("drain_data", bus.out_data, q[0].data);
      chk("drain_type", bus.out_type, q[0].typ);
      chk("drain_last", bus.out_last, q[0].last);
      chk("drain_a_rsel", 32'(bus.a_rsel), 32'(q[0].sel));
      chk("drain_raddr", bus.residue_raddr, q[0].raddr);
      if (rst) begin
        done = 1'b1;
      end else if (rdy) begin
        void'(q.pop_front());
        done = (q.size() == 0);
      end
    end
    if (!done) chk("drain_timeout", 32'(q.size()), 32'd0);
    cycles = cyc;
  endtask

  task automatic release_cycle(input bit keep_iv);
    @(negedge clk);
    bus.in_valid = keep_iv; bus.rready = 1'b0;
    #1;
    chk("release_rfin", bus.rfin, 1'b1);
    chk("release_out_valid", bus.out_valid, 1'b0);
    chk("release_in_ready", bus.in_ready, 1'b0);
    chk("release_start", bus.start, 1'b0);
  endtask

  vec_t tbl[7];

  initial begin
    int cyc;
    tbl[0] = '{1'b0, 1'b0, 16'h0000, 1'b0, 8'd0, 16'h0000, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 16'h1234, 1'b1, 8'd0, 16'h1234, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 16'hAAAA, 1'b0, 8'd0, 16'h0000, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 16'hBEEF, 1'b1, 8'd1, 16'hBEEF, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 16'h5555, 1'b1, 8'd2, 16'h5555, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 16'h0007, 1'b1, 8'd0, 16'h0007, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 16'hFFFF, 1'b1, 8'd1, 16'hFFFF, 1'b1, 1'b0};

    bus.in_valid = 1'b0; bus.in_data = 16'h0; bus.out_ready = 1'b0; bus.rready = 1'b0;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      rst = tbl[i].rst; bus.in_valid = tbl[i].iv; bus.in_data = tbl[i].din;
      #1;
      chk("tbl_x_wen", bus.x_wen, tbl[i].e_wen);
      chk("tbl_x_waddr", bus.x_waddr, tbl[i].e_addr);
      chk("tbl_x_din", bus.x_din, tbl[i].e_din);
      chk("tbl_in_ready", bus.in_ready, tbl[i].e_ready);
      chk("tbl_busy", bus.busy, tbl[i].e_busy);
      chk("tbl_start", bus.start, 1'b0);
      chk("tbl_out_valid", bus.out_valid, 1'b0);
      chk("tbl_frame_cnt", bus.frame_cnt, 32'd0);
    end

    // Frame A: ramp samples, long WAIT, full-rate drain.
    do_reset();
    enc_ofs = 0;
    fill(100, 1'b0, 0, 1'b0);
    wait_phase(50, 1'b0);
    drain(100, -1, 1'b0, cyc);
    chk("drain_cycles", 32'(cyc), 32'd170);
    release_cycle(1'b0);

    // Frame B: random data, gappy input, stalled drain.
    enc_ofs = int'($urandom_range(255));
    fill(60, 1'b1, 1, 1'b0);
    wait_phase(int'($urandom_range(5)), 1'b0);
    drain(50, -1, 1'b0, cyc);
    release_cycle(1'b0);

    // Frame C: reset while residue 77 is presented.
    enc_ofs = int'($urandom_range(255));
    fill(80, 1'b1, 2, 1'b0);
    wait_phase(2, 1'b0);
    drain(50, 77, 1'b0, cyc);
    @(negedge clk);
    rst = 1'b0; bus.in_valid = 1'b0; bus.rready = 1'b0;
    #1;
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_rfin", bus.rfin, 1'b0);
    chk("rst_start", bus.start, 1'b0);
    chk("rst_a_rsel", 32'(bus.a_rsel), 32'd0);
    chk("rst_raddr", bus.residue_raddr, 8'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_out_last", bus.out_last, 1'b0);
    chk("rst_frame_cnt", bus.frame_cnt, 32'd0);

    // Three back-to-back frames with in_valid held high throughout.
    for (int f = 0; f < 3; f++) begin
      enc_ofs = int'($urandom_range(255));
      fill(100, 1'b1, f, 1'b1);
      wait_phase(0, 1'b1);
      drain(70, -1, 1'b1, cyc);
      release_cycle(1'b1);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk("final_frame_cnt", bus.frame_cnt, 32'd3);
    chk("final_in_ready", bus.in_ready, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/lpc_frame_sequencer.md
# lpc_frame_sequencer

Frame-level scheduler wrapping the LPC encoder core. Accepts a 16-bit audio sample stream, loads each 160-sample frame into the encoder's input register, launches encoding with `start`, waits for `rready`, drains the 10 coefficients and 160 residues onto a 32-bit output stream, then releases the core with `rfin`. This is the only master of the encoder's write, read and handshake ports; it sits between the audio front end and the bitstream packer.

## Interface
Parameters:
- FRAME_LEN, 160, samples per frame; also the residue count (at most 256).
- ORDER, 10, LPC coefficient count; `a_rsel` width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; also drives encoder reset.
- in_valid  in  1  sample available.
- in_ready  out  1  sample accepted when in_valid & in_ready.
- in_data  in  16  signed PCM sample.
- out_valid  out  1  output beat available.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  32  coefficient (raw) or residue (sign-extended).
- out_type  out  1  0 = coefficient, 1 = residue.
- out_last  out  1  final beat of the frame (residue FRAME_LEN-1).
- start  out  1  one-cycle encoder launch pulse.
- rfin  out  1  one-cycle pulse: results consumed.
- rready  in  1  level from encoder: results readable.
- x_wen  out  1  encoder input-register write enable.
- x_waddr  out  8  write address.
- x_din  out  16  write data.
- residue_raddr  out  8  residue read address.
- residue_dout  in  16  residue data, combinational from address.
- a_rsel  out  ORDER  one-hot coefficient select.
- a_dout  in  32  coefficient data, combinational from select.
- busy  out  1  high in every state except FILL.
- frame_cnt  out  16  completed frames, wraps modulo 2^16.

## Operation
- States: FILL, LAUNCH, WAIT, DRAIN_A, DRAIN_R, RELEASE.
- FILL: in_ready=1. On each accepted sample: x_wen=1, x_waddr=idx, x_din=in_data, same cycle (combinational pass-through); idx increments. On acceptance at idx=FRAME_LEN-1: idx clears and the state moves to LAUNCH.
- LAUNCH: start=1 for exactly one cycle, then WAIT.
- WAIT: hold until rready=1, then DRAIN_A with idx=0.
- DRAIN_A: a_rsel = 1<<idx; out_valid=1; out_data=a_dout; out_type=0. On handshake idx++; after idx=ORDER-1 the state moves to DRAIN_R with idx=0.
- DRAIN_R: residue_raddr=idx; out_data={{16{residue_dout[15]}},residue_dout}; out_type=1; out_last=(idx==FRAME_LEN-1). Handshake on the last beat moves to RELEASE.
- RELEASE: rfin=1 for one cycle; frame_cnt++; state returns to FILL with idx=0.
- a_rsel=0 outside DRAIN_A. residue_raddr=0 outside DRAIN_R. x_wen=0 outside FILL.
- Address and select registers change only on a handshake, so out_data stays stable while out_valid & !out_ready.
- in_ready=0 in every state except FILL. Samples are never dropped; the upstream is backpressured.
- rready low during WAIT: wait indefinitely; no timeout.
- rready already high on entering WAIT: proceed the next cycle.

## Timing
- Reset values: FILL, idx=0, frame_cnt=0, in_ready=1, and all other outputs 0.
- Reset mid-frame in any state: next cycle in FILL with partial data discarded and no start/rfin pulse.
- Accepting sample FRAME_LEN-1 in cycle T gives start=1 in T+1 and WAIT from T+2.
- rready seen in WAIT at cycle T gives the first coefficient beat valid in T+1.
- Back-to-back drain at 1 beat/cycle when out_ready=1 held: 170 cycles.
- Last residue handshake at T gives rfin=1 in T+1 and in_ready=1 in T+2.
- Minimum frame period with no stalls: FRAME_LEN+1+1+(WAIT)+ORDER+FRAME_LEN+1 cycles.

## Test plan
- Reset then stream 160 samples (value = index) with in_valid held high: x_wen fires at addresses 0..159 with matching data, start pulses once in the cycle after sample 159, in_ready=0 afterwards.
- Hold rready=0 for 50 cycles after start: no out_valid and in_ready stays 0. Raise rready: first beat is a_rsel=10'b1 with out_type=0.
- Model a_dout=k*0x01010101 and residue_dout=0x8000+idx with out_ready=1: 10 coefficient beats, then 160 residue beats with data 0xFFFF8000.. sign-extended, out_last only on beat 170, rfin one cycle later, frame_cnt=1.
- Random out_ready (50% duty) during the drain: out_data stable across stalls, no beat lost or duplicated, order identical to the no-stall case.
- Assert reset during DRAIN_R at residue 77: next cycle FILL with all outputs at reset values and no rfin. A fresh frame then completes normally.
- Run 3 consecutive frames with in_valid held high: in_ready is low throughout busy, and frame_cnt reads 1, 2, 3 after each rfin.
